sky130_ef_ip__rc_osc_clkdiv: RTL

SKY130_EF_IP__RC_OSC_CLKDIV -- requirements
Module: sky130_ef_ip__rc_osc_clkdiv

---
 rtl/sky130_ef_ip__rc_osc_clkdiv.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sky130_ef_ip__rc_osc_clkdiv.sv
// RC oscillator clock divider: settle, run, graceful stop.
// Glitch-free divided clock with deferred divisor update.
module sky130_ef_ip__rc_osc_clkdiv #(
   parameter int DIV_W      = 8,
   parameter int SETTLE_CYC = 16,
   parameter int DIV_RST    = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [DIV_W-1:0] div,
   input  logic             div_load,
   output logic             div_ack,
   output logic             dout,
   output logic             ready,
   output logic [CNT_W-1:0] edge_cnt
);

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic [15:0]      SETTLE_V = 16'(SETTLE_CYC);
   localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

   state_t             state, state_d;
   logic [15:0]        settle_cnt, settle_d;
   logic [DIV_W-1:0]   hc, hc_d;
   logic [DIV_W-1:0]   cur_div, cur_d;
   logic [DIV_W-1:0]   pend, pend_d;
   logic               pend_valid, pv_d;
   logic               dout_d, ready_d, ack_d;
   logic [CNT_W-1:0]   ecnt_d;
   logic               tgl;

   // Phase ends when the half-period counter reaches the divisor.
   assign tgl = (hc == cur_div);

   // State register: reset forces OFF with no phase completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OFF;
      end else begin
         state <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         hc         <= '0;
         cur_div    <= DIV_INIT;
         pend       <= '0;
         pend_valid <= 1'b0;
         dout       <= 1'b0;
         ready      <= 1'b0;
         div_ack    <= 1'b0;
         edge_cnt   <= '0;
      end else begin
         settle_cnt <= settle_d;
         hc         <= hc_d;
         cur_div    <= cur_d;
         pend       <= pend_d;
         pend_valid <= pv_d;
         dout       <= dout_d;
         ready      <= ready_d;
         div_ack    <= ack_d;
         edge_cnt   <= ecnt_d;
      end
   end

   // Next-state and next-value logic.
   always_comb begin
      state_d  = state;
      settle_d = settle_cnt;
      hc_d     = hc;
      dout_d   = dout;
      cur_d    = cur_div;
      pend_d   = pend;
      pv_d     = pend_valid;
      ack_d    = 1'b0;
      ecnt_d   = edge_cnt;
      unique case (state)
         OFF: begin
            hc_d     = '0;
            dout_d   = 1'b0;
            settle_d = '0;
            if (ena) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (!ena) begin
               state_d  = OFF;
               settle_d = '0;
            end else if (settle_cnt == SETTLE_V) begin
               state_d  = RUN;
               settle_d = '0;
            end else begin
               settle_d = settle_cnt + 16'd1;
            end
         end
         RUN, STOP: begin
            if (state == RUN && !ena && !dout) begin
               // Low phase may be cut short: output is already low.
               state_d = OFF;
               hc_d    = '0;
               dout_d  = 1'b0;
            end else begin
               if (tgl) begin
                  hc_d   = '0;
                  dout_d = !dout;
                  if (!dout) begin
                     ecnt_d = edge_cnt + CNT_W'(1);
                  end
                  // New divisor only at the falling edge, never mid-phase.
                  if (dout && pend_valid) begin
                     cur_d = pend;
                     pv_d  = 1'b0;
                     ack_d = 1'b1;
                  end
               end else begin
                  hc_d = hc + DIV_W'(1);
               end
               if (ena) begin
                  state_d = RUN;
               end else if (tgl) begin
                  state_d = OFF;
               end else begin
                  state_d = STOP;
               end
            end
         end
         default: begin
            state_d = OFF;
         end
      endcase
      // A load always wins over the clear from an application.
      if (div_load) begin
         pend_d = div;
         pv_d   = 1'b1;
      end
   end

   // ready mirrors the state being entered so it aligns with RUN.
   assign ready_d = (state_d == RUN);

endmodule
